// File: rtl/mux_uart_multi_if.sv
// CPU-side register bus for the multi-channel UART.
// One-cycle strobed access, registered read data and interrupt outputs.
interface mux_uart_multi_if;
   logic       selected;
   logic [4:0] address;
   logic       write_en;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       int_reqn;
   logic [3:0] irq_number;

   modport master (
      output selected, address, write_en, data_in,
      input  data_out, int_reqn, irq_number
   );

   modport slave (
      input  selected, address, write_en, data_in,
      output data_out, int_reqn, irq_number
   );
endinterface

// File: rtl/mux_uart_multi.sv
// Up to four independent UART channels behind one register bus,
// each with RX/TX FIFOs and a prioritised interrupt output.
module mux_uart_multi #(
   parameter int CHANNELS   = 4,
   parameter int FIFO_DEPTH = 16,
   parameter int CLK_HZ     = 27_000_000
) (
   input  logic                clk,
   input  logic                reset,
   mux_uart_multi_if.slave     bus,
   input  logic [CHANNELS-1:0] uart_rx,
   output logic [CHANNELS-1:0] uart_tx
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

   localparam logic [2:0] REG_CTRL = 3'd0;
   localparam logic [2:0] REG_BAUD = 3'd1;
   localparam logic [2:0] REG_DATA = 3'd2;
   localparam logic [2:0] REG_STAT = 3'd3;
   localparam logic [2:0] REG_LVL  = 3'd4;
   localparam logic [2:0] REG_EN   = 3'd5;
   localparam logic [2:0] REG_CMD  = 3'd6;

   // Slow rates at high clk overflow the 16-bit counter; clamp them.
   function automatic logic [15:0] sat_div(input int baud);
      int d;
      d = CLK_HZ / baud;
      return (d > 65535) ? 16'hFFFF : d[15:0];
   endfunction

   localparam logic [15:0] DIV_TAB [8] = '{
      sat_div(75),   sat_div(300),  sat_div(1200),  sat_div(2400),
      sat_div(4800), sat_div(9600), sat_div(19200), sat_div(38400)
   };

   typedef enum logic [2:0] {
      T_IDLE, T_START, T_DATA, T_PAR, T_STOP, T_STOP2
   } tx_st_t;

   typedef enum logic [2:0] {
      R_IDLE, R_START, R_DATA, R_PAR, R_STOP
   } rx_st_t;

   logic [1:0] acc_ch;
   logic [2:0] acc_reg;
   assign acc_ch  = bus.address[4:3];
   assign acc_reg = bus.address[2:0];

   logic [7:0]          ch_rdata [CHANNELS];
   logic [3:0]          ch_lvl   [CHANNELS];
   logic [CHANNELS-1:0] ch_req;

   for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
      logic          hit, wr, rd;
      logic [4:0]    ctrl;
      logic [2:0]    baud;
      logic [3:0]    lvl;
      logic [1:0]    en;
      logic          ovr, ferr, perr;
      logic [7:0]    tx_mem [FIFO_DEPTH];
      logic [7:0]    rx_mem [FIFO_DEPTH];
      logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
      logic [CW-1:0] tx_cnt, rx_cnt;
      logic          tx_full, tx_empty, tx_idle;
      logic          tx_push, tx_push_ok, tx_load, tx_done;
      logic          rx_full, rx_empty;
      logic          rx_push, rx_push_ok, rx_pop_req, rx_pop;
      logic          tx_flush, rx_flush, clr_err, restore;
      tx_st_t        tx_st;
      logic [15:0]   tx_tmr, tx_dv;
      logic [7:0]    tx_sh, tx_head, tx_mask;
      logic [2:0]    tx_bit, tx_nb;
      logic          tx_pen, tx_two, tx_par, tx_line;
      rx_st_t        rx_st;
      logic [15:0]   rx_tmr, rx_dv;
      logic [7:0]    rx_sh;
      logic [2:0]    rx_bit, rx_nb;
      logic          rx_pen, rx_odd, rx_pbit, rx_s1, rx_s2;
      logic [7:0]    rdata;

      assign hit = bus.selected && (acc_ch == 2'(g));
      assign wr  = hit && bus.write_en;
      assign rd  = hit && !bus.write_en;

      assign tx_flush = wr && acc_reg == REG_CMD && bus.data_in[2];
      assign rx_flush = wr && acc_reg == REG_CMD && bus.data_in[1];
      assign clr_err  = wr && acc_reg == REG_CMD && bus.data_in[0];
      assign restore  = wr && acc_reg == REG_CMD && bus.data_in[3];

      assign tx_full  = tx_cnt == FULL;
      assign tx_empty = tx_cnt == '0;
      assign tx_idle  = tx_empty && tx_st == T_IDLE;
      assign tx_done  = tx_tmr == '0 &&
                        ((tx_st == T_STOP && !tx_two) || tx_st == T_STOP2);
      assign tx_load  = !tx_empty && (tx_st == T_IDLE || tx_done);
      assign tx_push  = wr && acc_reg == REG_DATA;
      assign tx_push_ok = tx_push && (!tx_full || tx_load);
      assign tx_head  = tx_mem[tx_rp];
      assign tx_mask  = 8'hFF >> (2'd3 - ctrl[2:1]);

      assign rx_full    = rx_cnt == FULL;
      assign rx_empty   = rx_cnt == '0;
      assign rx_push    = rx_st == R_STOP && rx_tmr == '0;
      assign rx_pop_req = rd && acc_reg == REG_DATA;
      // An empty FIFO still serves a byte arriving in the same cycle.
      assign rx_pop     = rx_pop_req && (!rx_empty || rx_push);
      assign rx_push_ok = rx_push && (!rx_full || rx_pop);

      always_comb begin
         rdata = 8'h00;
         case (acc_reg)
            REG_CTRL: rdata = {3'b000, ctrl};
            REG_BAUD: rdata = {5'b00000, baud};
            REG_DATA: rdata = rx_empty ? (rx_push ? rx_sh : 8'h00)
                                       : rx_mem[rx_rp];
            REG_STAT: rdata = {2'b00, perr, ferr, ovr,
                               tx_idle, !tx_full, !rx_empty};
            REG_LVL:  rdata = {4'b0000, lvl};
            REG_EN:   rdata = {6'b000000, en};
            default:  rdata = 8'h00;
         endcase
      end

      assign ch_rdata[g] = rdata;
      assign ch_lvl[g]   = lvl;
      assign ch_req[g]   = (en[0] && !rx_empty) || (en[1] && tx_idle);
      assign uart_tx[g]  = tx_line;

      always_ff @(posedge clk) begin
         if (tx_push_ok && !tx_flush) tx_mem[tx_wp] <= bus.data_in;
         if (rx_push_ok && !rx_flush) rx_mem[rx_wp] <= rx_sh;
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            ctrl   <= 5'h0C;
            baud   <= 3'd5;
            lvl    <= '0;
            en     <= '0;
            ovr    <= 1'b0;
            ferr   <= 1'b0;
            perr   <= 1'b0;
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
         end else begin
            if (wr) begin
               case (acc_reg)
                  REG_CTRL: ctrl <= bus.data_in[4:0];
                  REG_BAUD: baud <= bus.data_in[2:0];
                  REG_LVL:  lvl  <= bus.data_in[3:0];
                  REG_EN:   en   <= bus.data_in[1:0];
                  default:  ;
               endcase
            end
            if (restore) begin
               ctrl <= 5'h0C;
               baud <= 3'd5;
               lvl  <= '0;
               en   <= '0;
            end
            if (clr_err) begin
               ovr  <= 1'b0;
               ferr <= 1'b0;
               perr <= 1'b0;
            end
            if (rx_push && !rx_push_ok && !rx_flush) ovr <= 1'b1;
            if (rx_push) begin
               if (!rx_s2) ferr <= 1'b1;
               if (rx_pen && ((^rx_sh) ^ rx_odd) != rx_pbit) perr <= 1'b1;
            end
            if (tx_flush) begin
               tx_rp  <= tx_wp;
               tx_cnt <= '0;
            end else begin
               if (tx_push_ok) tx_wp <= tx_wp + AW'(1);
               if (tx_load)    tx_rp <= tx_rp + AW'(1);
               tx_cnt <= tx_cnt + CW'(tx_push_ok) - CW'(tx_load);
            end
            if (rx_flush) begin
               rx_rp  <= rx_wp;
               rx_cnt <= '0;
            end else begin
               if (rx_push_ok) rx_wp <= rx_wp + AW'(1);
               if (rx_pop)     rx_rp <= rx_rp + AW'(1);
               rx_cnt <= rx_cnt + CW'(rx_push_ok) - CW'(rx_pop);
            end
         end
      end

      // Frame settings are latched at load so mid-frame writes wait.
      always_ff @(posedge clk) begin
         if (reset) begin
            tx_st   <= T_IDLE;
            tx_line <= 1'b1;
            tx_tmr  <= '0;
            tx_dv   <= '0;
            tx_sh   <= '0;
            tx_bit  <= '0;
            tx_nb   <= '0;
            tx_pen  <= 1'b0;
            tx_two  <= 1'b0;
            tx_par  <= 1'b0;
         end else if (tx_load) begin
            tx_st   <= T_START;
            tx_line <= 1'b0;
            tx_dv   <= DIV_TAB[baud];
            tx_tmr  <= DIV_TAB[baud] - 16'd1;
            tx_sh   <= tx_head & tx_mask;
            tx_bit  <= '0;
            tx_nb   <= {1'b0, ctrl[2:1]} + 3'd4;
            tx_pen  <= ctrl[3];
            tx_two  <= ctrl[4];
            tx_par  <= (^(tx_head & tx_mask)) ^ ctrl[0];
         end else if (tx_st != T_IDLE) begin
            if (tx_tmr != '0) begin
               tx_tmr <= tx_tmr - 16'd1;
            end else begin
               tx_tmr <= tx_dv - 16'd1;
               unique case (tx_st)
                  T_START: begin
                     tx_st   <= T_DATA;
                     tx_line <= tx_sh[0];
                  end
                  T_DATA: begin
                     if (tx_bit == tx_nb) begin
                        tx_st   <= tx_pen ? T_PAR : T_STOP;
                        tx_line <= tx_pen ? tx_par : 1'b1;
                     end else begin
                        tx_bit  <= tx_bit + 3'd1;
                        tx_sh   <= tx_sh >> 1;
                        tx_line <= tx_sh[1];
                     end
                  end
                  T_PAR: begin
                     tx_st   <= T_STOP;
                     tx_line <= 1'b1;
                  end
                  T_STOP:  tx_st <= tx_two ? T_STOP2 : T_IDLE;
                  T_STOP2: tx_st <= T_IDLE;
                  default: tx_st <= T_IDLE;
               endcase
            end
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_st   <= R_IDLE;
            rx_tmr  <= '0;
            rx_dv   <= '0;
            rx_sh   <= '0;
            rx_bit  <= '0;
            rx_nb   <= '0;
            rx_pen  <= 1'b0;
            rx_odd  <= 1'b0;
            rx_pbit <= 1'b0;
         end else begin
            rx_s1 <= uart_rx[g];
            rx_s2 <= rx_s1;
            if (rx_st == R_IDLE) begin
               if (!rx_s2) begin
                  rx_st  <= R_START;
                  rx_dv  <= DIV_TAB[baud];
                  rx_tmr <= (DIV_TAB[baud] >> 1) - 16'd1;
                  rx_nb  <= {1'b0, ctrl[2:1]} + 3'd4;
                  rx_pen <= ctrl[3];
                  rx_odd <= ctrl[0];
                  rx_sh  <= '0;
                  rx_bit <= '0;
               end
            end else if (rx_tmr != '0) begin
               rx_tmr <= rx_tmr - 16'd1;
            end else begin
               rx_tmr <= rx_dv - 16'd1;
               unique case (rx_st)
                  R_START: rx_st <= rx_s2 ? R_IDLE : R_DATA;
                  R_DATA: begin
                     rx_sh[rx_bit] <= rx_s2;
                     if (rx_bit == rx_nb) begin
                        rx_st <= rx_pen ? R_PAR : R_STOP;
                     end else begin
                        rx_bit <= rx_bit + 3'd1;
                     end
                  end
                  R_PAR: begin
                     rx_pbit <= rx_s2;
                     rx_st   <= R_STOP;
                  end
                  R_STOP:  rx_st <= R_IDLE;
                  default: rx_st <= R_IDLE;
               endcase
            end
         end
      end
   end

   logic [7:0] rd_mux;
   logic [3:0] win_lvl;

   always_comb begin
      rd_mux = 8'h00;
      for (int i = 0; i < CHANNELS; i++) begin
         if (acc_ch == 2'(i)) rd_mux = ch_rdata[i];
      end
   end

   // Scan high to low so the lowest-numbered requester wins.
   always_comb begin
      win_lvl = 4'd0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (ch_req[i]) win_lvl = ch_lvl[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.data_out   <= 8'h00;
         bus.int_reqn   <= 1'b1;
         bus.irq_number <= 4'd0;
      end else begin
         if (bus.selected && !bus.write_en) bus.data_out <= rd_mux;
         bus.int_reqn   <= ~|ch_req;
         bus.irq_number <= win_lvl;
      end
   end

endmodule

// File: tb/tb_mux_uart_multi.sv
// Directed bench for mux_uart_multi: registers, TX/RX framing,
// FIFO overrun, interrupts, error flags and mid-frame reset.
module tb_mux_uart_multi;

   localparam int HZ     = 2_700_000;
   localparam int DIV96  = HZ / 9600;
   localparam int DIV384 = HZ / 38400;

   logic       clk;
   logic       reset;
   logic [3:0] urx;
   logic [3:0] utx;
   logic [7:0] v;
   logic [8:0] obs;
   int         total;
   int         bad;
   int         n;
   bit         seen;

   mux_uart_multi_if bus();

   mux_uart_multi #(
      .CHANNELS(4),
      .FIFO_DEPTH(4),
      .CLK_HZ(HZ)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .uart_rx(urx),
      .uart_tx(utx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input int cnt);
      repeat (cnt) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   task automatic wr(input int ch, input int r, input logic [7:0] dat);
      bus.selected = 1'b1;
      bus.write_en = 1'b1;
      bus.address  = {2'(ch), 3'(r)};
      bus.data_in  = dat;
      cyc(1);
      bus.selected = 1'b0;
      bus.write_en = 1'b0;
   endtask

   task automatic rd(input int ch, input int r, output logic [7:0] dat);
      bus.selected = 1'b1;
      bus.write_en = 1'b0;
      bus.address  = {2'(ch), 3'(r)};
      cyc(1);
      bus.selected = 1'b0;
      dat = bus.data_out;
   endtask

   task automatic rx_frame(input int ch, input logic [7:0] byt,
                           input int nb, input bit pen, input bit odd,
                           input int div, input int stop_low);
      logic p;
      p = odd;
      urx[ch] = 1'b0;
      cyc(div);
      for (int i = 0; i < nb; i++) begin
         urx[ch] = byt[i];
         p = p ^ byt[i];
         cyc(div);
      end
      if (pen) begin
         urx[ch] = p;
         cyc(div);
      end
      if (stop_low > 0) begin
         urx[ch] = 1'b0;
         cyc(stop_low);
      end
      urx[ch] = 1'b1;
      cyc(div - stop_low);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      urx   = 4'hF;
      bus.selected = 1'b0;
      bus.write_en = 1'b0;
      bus.address  = '0;
      bus.data_in  = '0;
      cyc(3);
      reset = 1'b0;

      chk("rst_tx", 16'(utx), 16'hF);
      chk("rst_intn", 16'(bus.int_reqn), 16'h1);
      chk("rst_irqnum", 16'(bus.irq_number), 16'h0);
      chk("rst_dout", 16'(bus.data_out), 16'h00);
      rd(0, 0, v); chk("rst_ctrl", 16'(v), 16'h0C);
      rd(0, 3, v); chk("rst_stat", 16'(v), 16'h06);
      rd(0, 7, v); chk("rsvd", 16'(v), 16'h00);
      rd(0, 1, v); chk("rst_baud", 16'(v), 16'h05);
      wr(0, 4, 8'h03);
      chk("dout_hold", 16'(bus.data_out), 16'h05);
      wr(0, 4, 8'h00);

      // 7E1 transmit of 0x41 at 9600
      wr(0, 2, 8'h41);
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         if (utx[0] == 1'b0) seen = 1;
         else cyc(1);
      end
      chk("tx_start_seen", 16'(seen), 16'h1);
      n = 0;
      while (utx[0] == 1'b0 && n < 5000) begin
         cyc(1);
         n++;
      end
      chk("tx_bit_period", 16'(n), 16'(DIV96));
      cyc(DIV96 / 2);
      obs[0] = utx[0];
      for (int k = 1; k < 9; k++) begin
         cyc(DIV96);
         obs[k] = utx[0];
      end
      chk("tx_frame_bits", 16'(obs), 16'h141);
      cyc(300);
      rd(0, 3, v); chk("tx_idle_after", 16'(v), 16'h06);

      // 8N1 receive on ch1 at 38400
      wr(1, 0, 8'h06);
      wr(1, 1, 8'h07);
      rx_frame(1, 8'hA5, 8, 0, 0, DIV384, 0);
      rd(1, 3, v); chk("rx_stat_ne", 16'(v), 16'h07);
      rd(1, 2, v); chk("rx_data", 16'(v), 16'hA5);
      rd(1, 3, v); chk("rx_stat_empty", 16'(v), 16'h06);

      // Overrun on ch2 with DEPTH+1 frames
      wr(2, 0, 8'h06);
      wr(2, 1, 8'h07);
      rx_frame(2, 8'h11, 8, 0, 0, DIV384, 0);
      rx_frame(2, 8'h22, 8, 0, 0, DIV384, 0);
      rx_frame(2, 8'h33, 8, 0, 0, DIV384, 0);
      rx_frame(2, 8'h44, 8, 0, 0, DIV384, 0);
      rx_frame(2, 8'h55, 8, 0, 0, DIV384, 0);
      rd(2, 3, v); chk("ovr_stat", 16'(v), 16'h0F);
      rd(2, 2, v); chk("ovr_b0", 16'(v), 16'h11);
      rd(2, 2, v); chk("ovr_b1", 16'(v), 16'h22);
      rd(2, 2, v); chk("ovr_b2", 16'(v), 16'h33);
      rd(2, 2, v); chk("ovr_b3", 16'(v), 16'h44);
      rd(2, 3, v); chk("ovr_sticky", 16'(v), 16'h0E);
      wr(2, 6, 8'h01);
      rd(2, 3, v); chk("ovr_clear", 16'(v), 16'h06);

      // Interrupts: ch3 RX level 9, ch2 TX-idle level 5 wins
      wr(3, 0, 8'h06);
      wr(3, 1, 8'h07);
      wr(3, 4, 8'h09);
      wr(3, 5, 8'h01);
      chk("irq_none", 16'(bus.int_reqn), 16'h1);
      rx_frame(3, 8'h3C, 8, 0, 0, DIV384, 0);
      cyc(2);
      chk("irq_req", 16'(bus.int_reqn), 16'h0);
      chk("irq_num9", 16'(bus.irq_number), 16'h9);
      wr(2, 4, 8'h05);
      wr(2, 5, 8'h02);
      cyc(2);
      chk("irq_prio", 16'(bus.irq_number), 16'h5);
      wr(2, 5, 8'h00);
      cyc(2);
      chk("irq_back9", 16'(bus.irq_number), 16'h9);
      rd(3, 2, v); chk("irq_data", 16'(v), 16'h3C);
      cyc(1);
      chk("irq_release", 16'(bus.int_reqn), 16'h1);

      // Framing error keeps byte; short glitch is rejected
      rx_frame(1, 8'h5A, 8, 0, 0, DIV384, (3 * DIV384) / 4);
      cyc(2 * DIV384);
      rd(1, 3, v); chk("ferr_stat", 16'(v), 16'h17);
      rd(1, 2, v); chk("ferr_data", 16'(v), 16'h5A);
      wr(1, 6, 8'h01);
      rd(1, 3, v); chk("ferr_clear", 16'(v), 16'h06);
      urx[1] = 1'b0;
      cyc(DIV384 / 4);
      urx[1] = 1'b1;
      cyc(3 * DIV384);
      rd(1, 3, v); chk("glitch_stat", 16'(v), 16'h06);
      rd(1, 2, v); chk("empty_read", 16'(v), 16'h00);

      // Parity error on default 7E1 channel, 7-bit byte zero-extended
      rx_frame(0, 8'h35, 7, 1, 1, DIV96, 0);
      rd(0, 3, v); chk("perr_stat", 16'(v), 16'h27);
      rd(0, 2, v); chk("perr_data", 16'(v), 16'h35);

      // Restore defaults command
      wr(1, 6, 8'h08);
      rd(1, 0, v); chk("restore_ctrl", 16'(v), 16'h0C);
      rd(1, 1, v); chk("restore_baud", 16'(v), 16'h05);

      // TX FIFO fills behind a busy shifter, then flush
      wr(2, 2, 8'h01);
      wr(2, 2, 8'h02);
      wr(2, 2, 8'h03);
      wr(2, 2, 8'h04);
      wr(2, 2, 8'h05);
      rd(2, 3, v); chk("txfull_stat", 16'(v), 16'h00);
      wr(2, 6, 8'h04);
      rd(2, 3, v); chk("txflush_stat", 16'(v), 16'h02);

      // Reset in the middle of a TX frame
      wr(0, 2, 8'h55);
      wr(0, 2, 8'h66);
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         if (utx[0] == 1'b0) seen = 1;
         else cyc(1);
      end
      chk("rst_tx_start", 16'(seen), 16'h1);
      cyc(3 * DIV96);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      chk("midrst_tx", 16'(utx), 16'hF);
      chk("midrst_intn", 16'(bus.int_reqn), 16'h1);
      rd(0, 3, v); chk("midrst_stat", 16'(v), 16'h06);
      rd(2, 5, v); chk("midrst_en", 16'(v), 16'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux_uart_multi.md
MUX_UART_MULTI -- requirements
Module: mux_uart_multi

Interface
REQ-001 The block SHALL provide parameter CHANNELS, default 4 (range 1-4): number of independent UART channels.
REQ-002 The block SHALL provide parameter FIFO_DEPTH, default 16 (power of two, 2-256): depth of each RX FIFO and each TX FIFO.
REQ-003 The block SHALL provide parameter CLK_HZ, default 27_000_000: clk frequency used to derive baud divisors.
REQ-004 clk  input  1  single clock for all logic; reset is synchronous and active-high.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 selected  input  1  one-cycle access strobe; exactly one cycle per CPU access.
REQ-007 address  input  5  [4:3] channel, [2:0] register.
REQ-008 write_en  input  1  1 = write access, 0 = read access while selected.
REQ-009 data_in  input  8  write data.
REQ-010 data_out  output  8  registered read data.
REQ-011 uart_rx  input  CHANNELS  serial inputs, idle high, asynchronous.
REQ-012 uart_tx  output  CHANNELS  serial outputs, idle high.
REQ-013 int_reqn  output  1  active-low interrupt request.
REQ-014 irq_number  output  4  interrupt level of the winning channel.

Function
REQ-015 Registers per channel SHALL be: 0 control RW; 1 baud RW; 2 data; 3 status RO; 4 irq level RW [3:0]; 5 irq enable RW; 6 command WO; 7 reserved (reads 0).
REQ-016 Control bits SHALL be: [0] odd parity; [2:1] data bits minus 5 (5-8); [3] parity enable; [4] two stop bits.
REQ-017 Baud [2:0] SHALL select 75/300/1200/2400/4800/9600/19200/38400; divisor = CLK_HZ/baud, elaboration-time constants, 16-bit counter.
REQ-018 A data write SHALL push into the TX FIFO; writes while full SHALL be dropped without side effects.
REQ-019 A data read SHALL return the RX FIFO head and pop it; reading an empty FIFO SHALL return 0x00 and not pop.
REQ-020 Status bits SHALL be: [0] RX not empty; [1] TX not full; [2] TX idle (FIFO empty, shifter idle); [3] overrun; [4] framing error; [5] parity error; [7:6] 0.
REQ-021 Irq enable bits SHALL be: [0] RX not empty; [1] TX idle.
REQ-022 Command writes SHALL act on set bits: [0] clear error flags; [1] flush RX FIFO; [2] flush TX FIFO; [3] restore channel defaults.
REQ-023 Read data SHALL be valid on data_out the cycle after selected; data_out SHALL otherwise hold its last value.
REQ-024 Accesses to channels >= CHANNELS SHALL read 0x00 and ignore writes.
REQ-025 TX FSM SHALL be IDLE -> START -> DATA (LSB first, N bits) -> PARITY (if enabled) -> STOP -> STOP2 (if two stop bits) -> IDLE or START; each state lasts exactly one divisor of clk cycles.
REQ-026 TX SHALL load the next FIFO byte on the final STOP cycle with no idle gap when the FIFO is non-empty.
REQ-027 Parity SHALL be XOR of the N data bits, inverted when odd parity is selected.
REQ-028 uart_rx SHALL pass a 2-flop synchroniser before any use.
REQ-029 RX FSM SHALL be IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
REQ-030 RX START SHALL re-sample the line at half a divisor; if the line is high, RX SHALL return to IDLE as a glitch.
REQ-031 RX SHALL sample each bit at mid-bit, i.e. a full divisor after the previous sample.
REQ-032 At the STOP sample, a low line SHALL set framing error; a parity mismatch SHALL set parity error.
REQ-033 At the STOP sample, the byte SHALL be pushed zero-extended; if the RX FIFO is full, the byte SHALL be dropped and overrun set.
REQ-034 A simultaneous push and pop SHALL both complete, leaving the count unchanged, including when full or empty.
REQ-035 A configuration write mid-frame SHALL take effect at the next start bit only.
REQ-036 A channel SHALL request an interrupt while (en[0] AND RX not empty) OR (en[1] AND TX idle).
REQ-037 int_reqn SHALL be low while any channel requests; irq_number SHALL be the level of the lowest-numbered requesting channel, registered, updated each cycle.

Reset
REQ-038 On reset, uart_tx SHALL be all ones, int_reqn 1, irq_number 0, data_out 0x00, and all FIFOs empty.
REQ-039 On reset, all FSMs SHALL enter IDLE and all error flags SHALL clear.
REQ-040 On reset, each channel SHALL default to 9600 7E1: control 0x0C, baud 5, irq level 0, irq enable 0.

Verification
REQ-041 Reset, write 0x41 to ch0 data -> uart_tx[0]: start, 1000001, even parity 0, stop; 2812 clk per bit.
REQ-042 Ch1 control 0x06 (8N1), baud 7; drive 0xA5 on uart_rx[1] -> status[0]=1; data read returns 0xA5; status[0]=0.
REQ-043 Send FIFO_DEPTH+1 bytes to ch2 without reading -> first FIFO_DEPTH bytes retained; status[3]=1; command 0x01 clears it.
REQ-044 Ch3 irq level 9, enable 0x01, receive byte -> int_reqn=0, irq_number=9; pop -> int_reqn=1 next cycle.
REQ-045 Hold uart_rx low at the stop bit -> framing error set, byte still pushed; 1/4-bit low glitch -> no byte pushed.
REQ-046 Assert reset mid-TX frame -> uart_tx high next cycle; FIFO empty; status[2]=1.
